// File: rtl/conv_layer_engine.sv
// conv_layer_engine: stride-1 unpadded multi-channel 2D convolution with a
// sequential MAC, optional ReLU and output saturation, RAM-to-RAM.
module conv_layer_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 6,
  parameter int IN_W   = 32,
  parameter int IN_H   = 32,
  parameter int K      = 5,
  parameter int DA_W   = (IN_CH*IN_H*IN_W > 1) ? $clog2(IN_CH*IN_H*IN_W) : 1,
  parameter int WA_W   = (OUT_CH*IN_CH*K*K > 1) ? $clog2(OUT_CH*IN_CH*K*K) : 1,
  parameter int BA_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  parameter int OA_W   = (OUT_CH*(IN_H-K+1)*(IN_W-K+1) > 1) ?
                         $clog2(OUT_CH*(IN_H-K+1)*(IN_W-K+1)) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] weight_in,
  input  logic signed [DATA_W-1:0] bias_in,
  output logic [DA_W-1:0]          data_addr,
  output logic [WA_W-1:0]          weight_addr,
  output logic [BA_W-1:0]          bias_addr,
  output logic [OA_W-1:0]          out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_wren,
  output logic                     busy,
  output logic                     done
);

  localparam int OUT_W = IN_W - K + 1;
  localparam int OUT_H = IN_H - K + 1;
  localparam int AW = 2 * DATA_W;
  localparam int CB = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KB = (K > 1) ? $clog2(K) : 1;
  localparam int XB = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YB = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OB = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  localparam logic signed [AW-1:0] SMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LAST  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic           relu_q, relu_d;
  logic [OB-1:0]  o_q, o_d;
  logic [YB-1:0]  oy_q, oy_d;
  logic [XB-1:0]  ox_q, ox_d;
  logic [CB-1:0]  c_q, c_d;
  logic [KB-1:0]  ky_q, ky_d;
  logic [KB-1:0]  kx_q, kx_d;
  logic           vld_q, vld_d;
  logic           first_q, first_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] prod, shft;
  logic [DATA_W-1:0]    res;
  logic                 tap0;

  assign tap0 = (c_q == '0) && (ky_q == '0) && (kx_q == '0);

  always_comb begin
    state_d = state_q;
    relu_d  = relu_q;
    o_d     = o_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    c_d     = c_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          relu_d  = relu_en;
          o_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          c_d     = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      S_FETCH: begin
        if (kx_q != KB'(K-1)) kx_d = kx_q + 1'b1;
        else begin
          kx_d = '0;
          if (ky_q != KB'(K-1)) ky_d = ky_q + 1'b1;
          else begin
            ky_d = '0;
            if (c_q != CB'(IN_CH-1)) c_d = c_q + 1'b1;
            else begin
              c_d     = '0;
              state_d = S_LAST;
            end
          end
        end
      end
      S_LAST: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_FETCH;
        if (ox_q != XB'(OUT_W-1)) ox_d = ox_q + 1'b1;
        else begin
          ox_d = '0;
          if (oy_q != YB'(OUT_H-1)) oy_d = oy_q + 1'b1;
          else begin
            oy_d = '0;
            if (o_q != OB'(OUT_CH-1)) o_d = o_q + 1'b1;
            else begin
              o_d     = '0;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM data arrives one cycle after its FETCH, so the MAC trails by one
  always_comb begin
    vld_d   = (state_q == S_FETCH);
    first_d = (state_q == S_FETCH) && tap0;
    prod    = AW'(data_in) * AW'(weight_in);
    shft    = prod >>> FRAC;
    acc_d   = acc_q;
    if (vld_q) acc_d = (first_q ? AW'(bias_in) : acc_q) + shft;
  end

  always_comb begin
    res = acc_q[DATA_W-1:0];
    if (relu_q && acc_q[AW-1]) res = '0;
    else if (acc_q > SMAX)     res = SMAX[DATA_W-1:0];
    else if (acc_q < SMIN)     res = SMIN[DATA_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      relu_q  <= 1'b0;
      o_q     <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      c_q     <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      relu_q  <= relu_d;
      o_q     <= o_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      c_q     <= c_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      acc_q   <= acc_d;
    end
  end

  assign data_addr = DA_W'(c_q) * DA_W'(IN_H*IN_W)
                   + (DA_W'(oy_q) + DA_W'(ky_q)) * DA_W'(IN_W)
                   + DA_W'(ox_q) + DA_W'(kx_q);
  assign weight_addr = ((WA_W'(o_q) * WA_W'(IN_CH) + WA_W'(c_q)) * WA_W'(K)
                     + WA_W'(ky_q)) * WA_W'(K) + WA_W'(kx_q);
  assign bias_addr = BA_W'(o_q);
  assign out_addr  = OA_W'(o_q) * OA_W'(OUT_H*OUT_W)
                   + OA_W'(oy_q) * OA_W'(OUT_W) + OA_W'(ox_q);
  assign out_wren  = (state_q == S_WRITE);
  assign out_data  = out_wren ? res : '0;
  assign busy      = (state_q == S_FETCH) || (state_q == S_LAST) ||
                     (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_layer_engine.sv
// tb_conv_layer_engine: random and directed passes of conv_layer_engine
// against a plain-arithmetic convolution model.
module tb_conv_layer_engine;
  localparam int DW = 32;
  localparam int FR = 4;
  localparam int ICH = 2;
  localparam int OCH = 2;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int KK = 2;
  localparam int OW = IW - KK + 1;
  localparam int OH = IH - KK + 1;
  localparam int NT = ICH * KK * KK;
  localparam int NPIX = OCH * OH * OW;
  localparam int ND = ICH * IH * IW;
  localparam int NWT = OCH * ICH * KK * KK;
  localparam int DA = $clog2(ND);
  localparam int WA = $clog2(NWT);
  localparam int BA = $clog2(OCH);
  localparam int OA = $clog2(NPIX);
  localparam int PASS = NPIX * (NT + 2) + 1;
  localparam int LIMIT = PASS + 100;

  logic clk = 1'b0;
  logic rst, start, relu_en;
  logic signed [DW-1:0] data_in, weight_in, bias_in;
  logic [DA-1:0] data_addr;
  logic [WA-1:0] weight_addr;
  logic [BA-1:0] bias_addr;
  logic [OA-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic out_wren, busy, done;

  logic [DW-1:0] dmem [2**DA];
  logic [DW-1:0] wmem [2**WA];
  logic [DW-1:0] bmem [2**BA];
  logic [DW-1:0] expv [NPIX];

  int total = 0;
  int bad = 0;
  int wa[$];
  logic [DW-1:0] wd[$];
  int wc[$];
  int done_cyc[$];
  logic busy1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_in   <= dmem[data_addr];
    weight_in <= wmem[weight_addr];
    bias_in   <= bmem[bias_addr];
  end

  conv_layer_engine #(
    .DATA_W(DW), .FRAC(FR), .IN_CH(ICH), .OUT_CH(OCH),
    .IN_W(IW), .IN_H(IH), .K(KK)
  ) dut (
    .Clk(clk), .Reset(rst), .start(start), .relu_en(relu_en),
    .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
    .data_addr(data_addr), .weight_addr(weight_addr),
    .bias_addr(bias_addr), .out_addr(out_addr), .out_data(out_data),
    .out_wren(out_wren), .busy(busy), .done(done)
  );

  // 0 small random, 1 full random, 2 sat+, 3 sat-, 4 bias -7 zero weights
  task automatic fill_mem(input int mode);
    for (int i = 0; i < 2**DA; i++)
      case (mode)
        0:       dmem[i] = 32'($urandom_range(0, 8191)) - 32'd4096;
        2, 3:    dmem[i] = 32'h4000_0000;
        default: dmem[i] = $urandom();
      endcase
    for (int i = 0; i < 2**WA; i++)
      case (mode)
        0:       wmem[i] = 32'($urandom_range(0, 1023)) - 32'd512;
        1:       wmem[i] = $urandom();
        2:       wmem[i] = 32'd64;
        3:       wmem[i] = -32'sd64;
        default: wmem[i] = '0;
      endcase
    for (int i = 0; i < 2**BA; i++)
      case (mode)
        0:       bmem[i] = 32'($urandom_range(0, 65535)) - 32'd32768;
        1:       bmem[i] = $urandom();
        4:       bmem[i] = -32'sd7;
        default: bmem[i] = '0;
      endcase
  endtask

  task automatic model(input bit relu);
    longint acc;
    for (int o = 0; o < OCH; o++)
      for (int oy = 0; oy < OH; oy++)
        for (int ox = 0; ox < OW; ox++) begin
          acc = longint'($signed(bmem[o]));
          for (int c = 0; c < ICH; c++)
            for (int ky = 0; ky < KK; ky++)
              for (int kx = 0; kx < KK; kx++)
                acc += (longint'($signed(dmem[c*IH*IW + (oy+ky)*IW + ox+kx])) *
                        longint'($signed(wmem[((o*ICH+c)*KK+ky)*KK+kx]))) >>> FR;
          if (relu && acc < 0)                 expv[(o*OH+oy)*OW+ox] = '0;
          else if (acc > 64'sh7fff_ffff)       expv[(o*OH+oy)*OW+ox] = 32'h7fff_ffff;
          else if (acc < -64'sh8000_0000)      expv[(o*OH+oy)*OW+ox] = 32'h8000_0000;
          else                                 expv[(o*OH+oy)*OW+ox] = acc[31:0];
        end
  endtask

  // Caller is at a negedge; start is raised immediately, k counts cycles after e0
  task automatic run_pass(input bit relu, input int mid_start,
                          input bit start_in_done, output int cyc, output bit tmo);
    wa.delete(); wd.delete(); wc.delete(); done_cyc.delete();
    tmo = 1'b1;
    cyc = 0;
    start = 1'b1;
    relu_en = relu;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      start = (k == mid_start);
      relu_en = ~relu;
      if (k == 1) busy1 = busy;
      if (out_wren) begin
        wa.push_back(int'(out_addr));
        wd.push_back(out_data);
        wc.push_back(k);
      end
      if (done) begin
        done_cyc.push_back(k);
        start = start_in_done;
      end else if (!busy && done_cyc.size() > 0) begin
        cyc = done_cyc[0];
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, out_wren} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl got %b want 000", {busy, done, out_wren});
    end
    total++;
    if (data_addr !== '0 || weight_addr !== '0 || bias_addr !== '0 || out_addr !== '0) begin
      bad++; $display("FAIL reset_addr got %0d %0d %0d %0d want 0 0 0 0",
                      data_addr, weight_addr, bias_addr, out_addr);
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL reset_data got %h want 0", out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc; bit tmo, relu;
    for (int r = 0; r < 4; r++) begin
      relu = r[0];
      fill_mem(r < 2 ? 0 : 1);
      model(relu);
      run_pass(relu, 0, 1'b0, cyc, tmo);
      total++;
      if (tmo || busy1 !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_start timeout %0d busy1 %b want 0 1", r, tmo, busy1);
      end
      total++;
      if (done_cyc.size() != 1 || cyc != PASS) begin
        bad++; $display("FAIL rnd%0d_done count %0d cycle %0d want 1 %0d",
                        r, done_cyc.size(), cyc, PASS);
      end
      total++;
      if (wa.size() != NPIX) begin
        bad++; $display("FAIL rnd%0d_nwr got %0d want %0d", r, wa.size(), NPIX);
      end
      for (int i = 0; i < wa.size() && i < NPIX; i++) begin
        total++;
        if (wa[i] != i || wd[i] !== expv[i] || wc[i] != i*(NT+2)+NT+2) begin
          bad++; $display("FAIL rnd%0d_px%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                          r, i, wa[i], wd[i], wc[i], i, expv[i], i*(NT+2)+NT+2);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int modes[5] = '{2, 3, 3, 4, 4};
    bit relus[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int cyc; bit tmo;
    for (int s = 0; s < 5; s++) begin
      fill_mem(modes[s]);
      model(relus[s]);
      run_pass(relus[s], 0, 1'b0, cyc, tmo);
      total++;
      if (tmo || wa.size() != NPIX) begin
        bad++; $display("FAIL sat%0d_nwr got %0d timeout %0d want %0d", s, wa.size(), tmo, NPIX);
      end
      for (int i = 0; i < wa.size() && i < NPIX; i++) begin
        total++;
        if (wa[i] != i || wd[i] !== expv[i]) begin
          bad++; $display("FAIL sat%0d_px%0d got a=%0d d=%h want a=%0d d=%h",
                          s, i, wa[i], wd[i], i, expv[i]);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    int cyc; bit tmo;
    fill_mem(0);
    model(1'b0);
    run_pass(1'b0, 3*(NT+2)+4, 1'b0, cyc, tmo);
    total++;
    if (tmo || done_cyc.size() != 1 || cyc != PASS) begin
      bad++; $display("FAIL busy_start got done=%0d cycle=%0d want 1 %0d",
                      done_cyc.size(), cyc, PASS);
    end
    total++;
    if (wa.size() != NPIX) begin
      bad++; $display("FAIL busy_start_nwr got %0d want %0d", wa.size(), NPIX);
    end
    for (int i = 0; i < wa.size() && i < NPIX; i++) begin
      total++;
      if (wa[i] != i || wd[i] !== expv[i]) begin
        bad++; $display("FAIL busy_start_px%0d got a=%0d d=%h want a=%0d d=%h",
                        i, wa[i], wd[i], i, expv[i]);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int cyc, nwr; bit tmo;
    fill_mem(0);
    model(1'b1);
    start = 1'b1; relu_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3*(NT+2) + 2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || out_wren !== 1'b0) begin
      bad++; $display("FAIL rstmid_pre got busy=%b wren=%b want 1 0", busy, out_wren);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, out_wren} !== 3'b000 || out_addr !== '0 || data_addr !== '0) begin
      bad++; $display("FAIL rstmid_post got ctl=%b oa=%0d da=%0d want 000 0 0",
                      {busy, done, out_wren}, out_addr, data_addr);
    end
    nwr = 0;
    repeat (2*(NT+2)) begin
      @(negedge clk);
      if (out_wren || busy) nwr++;
    end
    total++;
    if (nwr != 0) begin
      bad++; $display("FAIL rstmid_quiet got %0d active cycles want 0", nwr);
    end
    run_pass(1'b1, 0, 1'b0, cyc, tmo);
    total++;
    if (tmo || wa.size() != NPIX || cyc != PASS) begin
      bad++; $display("FAIL rstmid_rerun got n=%0d cycle=%0d want %0d %0d",
                      wa.size(), cyc, NPIX, PASS);
    end
    for (int i = 0; i < wa.size() && i < NPIX; i++) begin
      total++;
      if (wa[i] != i || wd[i] !== expv[i]) begin
        bad++; $display("FAIL rstmid_px%0d got a=%0d d=%h want a=%0d d=%h",
                        i, wa[i], wd[i], i, expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit tmo;
    fill_mem(1);
    model(1'b0);
    run_pass(1'b0, 0, 1'b1, cyc, tmo);
    total++;
    if (tmo || busy !== 1'b0 || done_cyc.size() != 1) begin
      bad++; $display("FAIL b2b_done_start got busy=%b done=%0d want 0 1",
                      busy, done_cyc.size());
    end
    fill_mem(0);
    model(1'b1);
    run_pass(1'b1, 0, 1'b0, cyc, tmo);
    total++;
    if (tmo || busy1 !== 1'b1 || cyc != PASS || wa.size() != NPIX) begin
      bad++; $display("FAIL b2b_second got busy1=%b cycle=%0d n=%0d want 1 %0d %0d",
                      busy1, cyc, wa.size(), PASS, NPIX);
    end
    for (int i = 0; i < wa.size() && i < NPIX; i++) begin
      total++;
      if (wa[i] != i || wd[i] !== expv[i]) begin
        bad++; $display("FAIL b2b_px%0d got a=%0d d=%h want a=%0d d=%h",
                        i, wa[i], wd[i], i, expv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_saturation();
    test_busy_start();
    test_reset_midpass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

Parametrised single-layer 2D convolution engine for the digit-recognition datapath. It reads a multi-channel feature map, kernel weights and per-output-channel biases from synchronous on-chip RAMs. It computes a stride-1, unpadded convolution with a sequential multiply-accumulate, applies optional ReLU and saturation, and writes one output word per pixel into a result RAM. It replaces fixed-geometry, single-channel convolution stages: one instance per network layer, each sequenced by the top-level controller through start/done.

## Interface
- DATA_W, 32, signed fixed-point word width of data, weight, bias and result
- FRAC, 16, fractional bits; each product is arithmetically shifted right by FRAC
- IN_CH, 1, input channels
- OUT_CH, 6, output channels
- IN_W, 32, input row pitch and width (pixels)
- IN_H, 32, input height
- K, 5, square kernel size; OUT_W = IN_W-K+1, OUT_H = IN_H-K+1
- DA_W / WA_W / BA_W / OA_W: address widths, each $clog2 of IN_CH*IN_H*IN_W, OUT_CH*IN_CH*K*K, OUT_CH and OUT_CH*OUT_H*OUT_W respectively (minimum 1)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE
- relu_en  in  1  ReLU enable; captured when start is accepted
- data_in  in  DATA_W  signed data RAM read data
- weight_in  in  DATA_W  signed weight RAM read data
- bias_in  in  DATA_W  signed bias RAM read data
- data_addr  out  DA_W  data RAM address
- weight_addr  out  WA_W  weight RAM address
- bias_addr  out  BA_W  bias RAM address (equals current output channel o)
- out_addr  out  OA_W  result RAM address
- out_data  out  DATA_W  result word
- out_wren  out  1  result RAM write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

## Operation
- All three source RAMs have a read latency of 1: an address driven in cycle t produces data in cycle t+1.
- Loop order, outermost to innermost: o (0..OUT_CH-1), oy, ox, then taps t = 0..N-1 with N = IN_CH*K*K. A tap decomposes as c = t/(K*K), ky = (t%(K*K))/K, kx = t%K. Use nested counters, not dividers.
- Address formulas:
  - data_addr = c*IN_H*IN_W + (oy+ky)*IN_W + (ox+kx)
  - weight_addr = ((o*IN_CH+c)*K+ky)*K+kx
  - out_addr = o*OUT_H*OUT_W + oy*OUT_W + ox
- States:
  - IDLE: on start, capture relu_en, clear all counters, go to FETCH.
  - FETCH: N cycles; drive the tap-t addresses, with t incrementing each cycle. After t = N-1, go to LAST.
  - LAST: accumulate the final tap, then go to WRITE.
  - WRITE: out_wren = 1 and out_data = the finished result. Then advance ox/oy/o. If the last pixel of the last channel has been written, go to DONE; otherwise go to FETCH with t = 0.
  - DONE: done = 1 for one cycle, then return to IDLE.
- Accumulator: signed, 2*DATA_W bits.
  - On the data-valid cycle of tap 0: acc = sext(bias_in) + (data_in*weight_in >>> FRAC).
  - On later taps: acc += (data_in*weight_in >>> FRAC).
  - The product is a full 2*DATA_W-bit signed value. The accumulator wraps silently at 2*DATA_W bits; that overflow is out of scope.
- Result:
  - If relu_en is set and acc < 0, the result is 0.
  - Otherwise the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- start while busy is ignored. relu_en changes mid-pass have no effect.

## Timing
- Reset values: busy = 0, done = 0, out_wren = 0. All address outputs = 0. out_data = 0. State = IDLE.
- Reset asserted mid-pass: all outputs reach their reset values on the next edge and no further writes occur. Partially written results are not rolled back.
- Start handshake: start is seen in IDLE at edge e0. From the cycle after e0, FETCH is active with busy = 1.
- Each output pixel takes exactly N+2 cycles (N FETCH, 1 LAST, 1 WRITE).
- Total pass length is OUT_CH*OUT_H*OUT_W*(N+2) cycles plus 1 DONE cycle; busy falls with DONE.
- A start asserted in the DONE cycle is ignored. A new pass may start on the first IDLE cycle.
- out_addr and out_data are valid only while out_wren = 1; out_addr equals the pixel being written.
- bias_addr is held at o for the whole channel. bias_in is sampled on the tap-0 data-valid cycle.

## Test plan
- Identity: IN_CH=1, OUT_CH=1, IN_W=IN_H=4, K=1, FRAC=0, data = 0..15, weight = 1, bias = 0 -> outputs 0..15 at out_addr 0..15. Pass takes 16*3+1 cycles after start.
- Box filter: IN_W=IN_H=4, K=3, FRAC=0, data all 2, weights all 1, bias 5 -> four writes of 23, at out_addr 0..3.
- Multichannel ordering: IN_CH=2, OUT_CH=2, K=2, FRAC=0. Channel 0 data = 1, channel 1 data = 10. Weights for o=0 are all 1; weights for o=1 are all 0 except the c=1 taps, which are 2. Bias = 0 -> o=0 pixels = 44, o=1 pixels = 80, at the correct out_addr ranges.
- ReLU and saturation:
  - Bias -7, all weights 0 -> 0 with relu_en = 1; 0xFFFFFFF9 with relu_en = 0.
  - FRAC=0, data = 0x40000000, weight = 4 -> 0x7FFFFFFF.
- Control:
  - Reset asserted during FETCH of pixel 3 -> out_wren stays 0 and busy drops next cycle; a fresh start yields the correct full result.
  - start pulsed while busy -> no restart, and the cycle count is unchanged.
  - done is high exactly once per pass.
